// File: rtl/union_frame_tx.sv
// Serial transmitter for the packed op-mode word {sel, data, op}: one-word holding
// register on a valid/ready input, framed as start/sel/payload/even-parity/stop.
module union_frame_tx #(
  parameter int DATA_W       = 10,
  parameter int OP_W         = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_op_sel,
  output logic              tx_line,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW = DATA_W + OP_W;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SEL     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_STOP    = 3'd5;

  // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on the registered hold_valid flag, never on in_valid.
  logic [2:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [BW-1:0] bit_cnt;
  logic          hold_valid;
  logic          hold_fresh;
  logic          hold_sel;
  logic [PW-1:0] hold_payload;
  logic [PW-1:0] shifter;
  logic          sel_r;
  logic          par_r;
  logic          bit_end;
  logic          accept;
  logic          drain;

  assign in_ready = ~hold_valid;
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign bit_end  = (cyc_cnt == CW'(CLKS_PER_BIT - 1));

  // From IDLE a freshly captured word waits one cycle so the start bit lands two
  // edges after the handshake; back-to-back frames launch straight out of STOP.
  assign drain = hold_valid &&
                 (((state == S_IDLE) && !hold_fresh) || ((state == S_STOP) && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid   <= 1'b0;
      hold_fresh   <= 1'b0;
      hold_sel     <= 1'b0;
      hold_payload <= '0;
    end else begin
      hold_fresh <= accept;
      if (accept) begin
        hold_valid   <= 1'b1;
        hold_sel     <= in_op_sel;
        hold_payload <= {in_data, in_op};
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      sel_r      <= 1'b0;
      par_r      <= 1'b0;
      tx_line    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_STOP) && bit_end;
      if (state != S_IDLE) begin
        cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
      end
      if (drain) begin
        shifter <= hold_payload;
        sel_r   <= hold_sel;
        par_r   <= ^{hold_sel, hold_payload};
        tx_line <= 1'b0;
        cyc_cnt <= '0;
        state   <= S_START;
      end else if (bit_end) begin
        case (state)
          S_START: begin
            state   <= S_SEL;
            tx_line <= sel_r;
          end
          S_SEL: begin
            state   <= S_PAYLOAD;
            bit_cnt <= '0;
            tx_line <= shifter[PW-1];
          end
          S_PAYLOAD: begin
            if (bit_cnt == BW'(PW - 1)) begin
              state   <= S_PARITY;
              tx_line <= par_r;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shifter <= {shifter[PW-2:0], 1'b0};
              tx_line <= shifter[PW-2];
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            tx_line <= 1'b1;
          end
          S_STOP: begin
            state <= S_IDLE;
          end
          default: begin
            state   <= S_IDLE;
            tx_line <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_union_frame_tx.sv
// Bench for union_frame_tx: a receiver-style monitor decodes frames from tx_line and
// compares them with frames built from the word-level rules at each handshake.
module tb_union_frame_tx;

  localparam int CPB = 4;
  localparam int FL  = 17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_op_sel, tx_line, busy, frame_done;
  logic [9:0] in_data;
  logic [2:0] in_op;
  logic       v1, rdy1, s1, tx1, busy1, done1;
  logic [9:0] d1;
  logic [2:0] o1;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int frames_seen = 0;
  int start_log[$];
  int done_log[$];
  logic [FL-1:0] exp_q[$];

  union_frame_tx #(.DATA_W(10), .OP_W(3), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_op_sel(in_op_sel),
    .tx_line(tx_line), .busy(busy), .frame_done(frame_done)
  );

  union_frame_tx #(.DATA_W(10), .OP_W(3), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .in_op(o1), .in_op_sel(s1),
    .tx_line(tx1), .busy(busy1), .frame_done(done1)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FL-1:0] build_frame(input logic [9:0] d, input logic [2:0] o,
                                                 input logic s);
    logic [12:0]   p;
    logic [FL-1:0] f;
    p     = {d, o};
    f[0]  = 1'b0;
    f[1]  = s;
    for (int i = 0; i < 13; i++) f[2+i] = p[12-i];
    f[15] = (($countones({s, p}) % 2) == 1);
    f[16] = 1'b1;
    return f;
  endfunction

  // scoreboard / monitor: decode the line of the CLKS_PER_BIT=4 instance
  logic [FL-1:0] mon_bits;
  int  mon_cnt = 0;
  bit  in_frame = 1'b0;
  bit  exp_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      mon_cnt  = 0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || frame_done) begin
        check("frame_done", frame_done, exp_done);
        if (frame_done) done_log.push_back(cyc);
      end
      exp_done = 1'b0;
      if (!in_frame && tx_line == 1'b0) begin
        in_frame = 1'b1;
        mon_cnt  = 0;
        start_log.push_back(cyc);
      end
      check("busy", busy, in_frame);
      if (in_frame) begin
        if (mon_cnt % CPB == 0) mon_bits[mon_cnt/CPB] = tx_line;
        else check("bit_hold", tx_line, mon_bits[mon_cnt/CPB]);
        mon_cnt++;
        if (mon_cnt == FL * CPB) begin
          in_frame = 1'b0;
          exp_done = 1'b1;
          frames_seen++;
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("frame_bits", mon_bits, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic send(input logic [9:0] d, input logic [2:0] o, input logic s,
                      input bit toggle, output int hs);
    in_valid = 1'b1;
    hs = -1;
    for (int k = 0; k < 400; k++) begin
      if (in_ready) begin
        in_data = d; in_op = o; in_op_sel = s;
        @(posedge clk);
        exp_q.push_back(build_frame(d, o, s));
        @(negedge clk);
        hs = cyc;
        in_valid = 1'b0;
        return;
      end
      if (toggle) begin
        in_data = 10'($urandom); in_op = 3'($urandom); in_op_sel = 1'($urandom);
      end else begin
        in_data = d; in_op = o; in_op_sel = s;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("handshake_timeout", in_ready, 1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int k = 0; k < budget && frames_seen < n; k++) @(negedge clk);
    check("frames_seen", frames_seen, n);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 2000 && cyc < target; k++) @(negedge clk);
  endtask

  int hs, hs2, hs3, base, s0, k;
  logic [FL-1:0] f1;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_op = '0; in_op_sel = 1'b0;
    v1 = 1'b0; d1 = '0; o1 = '0; s1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_line", tx_line, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_tx1", tx1, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // one-cycle bits: all-zero word, sel=0
    v1 = 1'b1;
    check("rdy1_idle", rdy1, 1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    hs = cyc;
    f1 = build_frame(10'h000, 3'b000, 1'b0);
    k = 0;
    while (tx1 && k < 10) begin @(negedge clk); k++; end
    check("lat_cpb1", cyc - hs, 2);
    for (int i = 0; i < 18; i++) begin
      if (i < FL) check("line_cpb1", tx1, f1[i]);
      else check("idle_cpb1", tx1, 1);
      check("done_cpb1", done1, (i == FL));
      @(negedge clk);
    end

    // single word, latency and frame_done position
    base = start_log.size();
    send(10'h2A5, 3'b101, 1'b1, 1'b0, hs);
    wait_frames(1, 200);
    if (start_log.size() > base && done_log.size() > 0) begin
      check("start_latency", start_log[base] - hs, 2);
      check("done_offset", done_log[done_log.size()-1] - start_log[base], FL * CPB);
    end else check("start_logged", start_log.size(), base + 1);

    // back-to-back frames and a third word stalled behind a full buffer
    base = start_log.size();
    send(10'h3FF, 3'b111, 1'b0, 1'b0, hs);
    send(10'h001, 3'b000, 1'b1, 1'b0, hs2);
    check("ready_after_second", in_ready, 0);
    send(10'($urandom), 3'($urandom), 1'($urandom), 1'b1, hs3);
    wait_frames(4, 400);
    if (start_log.size() >= base + 3) begin
      check("second_accept", hs2 - hs, 3);
      check("gap_1_2", start_log[base+1] - start_log[base], FL * CPB);
      check("third_accept", hs3 - start_log[base+1], 1);
      check("gap_2_3", start_log[base+2] - start_log[base+1], FL * CPB);
    end else check("starts_logged", start_log.size(), base + 3);

    // reset in the middle of payload bit 6 with a second word buffered
    s0 = frames_seen;
    base = start_log.size();
    send(10'($urandom), 3'($urandom), 1'($urandom), 1'b0, hs);
    send(10'($urandom), 3'($urandom), 1'($urandom), 1'b0, hs2);
    if (start_log.size() > base) wait_cyc(start_log[base] + 2 + 8 * CPB - 1);
    check("reset_point_reached", start_log.size(), base + 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_tx_line", tx_line, 1);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", frame_done, 0);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", frames_seen, s0);
    check("idle_after_reset", tx_line, 1);
    send(10'($urandom), 3'($urandom), 1'($urandom), 1'b0, hs);
    wait_frames(s0 + 1, 200);

    // random words with random idle gaps
    s0 = frames_seen;
    for (int w = 0; w < 5; w++) begin
      send(10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), hs);
      repeat ($urandom_range(0, 90)) @(negedge clk);
    end
    wait_frames(s0 + 5, 600);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
